i2c_encoder_target: RTL and testbench
=====================================

Name: i2c_encoder_target

Overview:
- I2C target (responder) that emulates the AS5600 magnetic encoder at 7-bit address 0x36.
- Serves the raw-angle registers to an I2C controller such as the swerve-module angle reader.
- Used in FPGA-in-loop benches and as a stand-in sensor when a physical AS5600 is absent. Angle value is supplied on a parallel input.
- Supports pointer write, repeated-start read, and auto-incrementing multi-byte reads.

Parameters:
- DEV_ADDR, 7'h36, 7-bit target address matched after START.
- STATUS_REG, 8'h0B, register address of the STATUS byte.
- ANGLE_REG, 8'h0C, register address of RAW_ANGLE high byte; low byte is ANGLE_REG+1.

Ports:
- clock  input  1  system clock; must be at least 16x the SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  I2C clock from pad, asynchronous.
- sda_in  input  1  I2C data from pad, asynchronous.
- sda_drive_low  output  1  1 = pull SDA low; top level forms the open-drain driver.
- angle_in  input  12  angle value to serve.
- magnet_detected  input  1  reported in STATUS bit 5.
- busy  output  1  high from an addressed START until STOP.
- reg_ptr  output  8  current register pointer.
- rd_strobe  output  1  one-cycle pulse when a byte is loaded for transmission.

Behaviour:
- Reset values:
  - sda_drive_low=0, busy=0, reg_ptr=0x00, rd_strobe=0.
  - State machine in IDLE; synchronizers preset to 1.
  - Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a registered edge detect.
  - Condition-to-action latency is 3 clock cycles.
- Bus condition detection:
  - START: sda falling while scl high.
  - STOP: sda rising while scl high.
  - Data bits are sampled on the scl rising edge. The target changes sda_drive_low only on the scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START:
  - Valid from any state, including a repeated start.
  - Clears the bit counter, enters ADDR, and releases SDA.
- STOP:
  - Valid from any state.
  - Goes to IDLE, releases SDA, and sets busy=0.
- ADDR:
  - Shift in 8 bits, MSB first.
  - If addr[7:1]==DEV_ADDR: set busy=1 and go to ADDR_ACK.
  - Otherwise go to IDLE with no ACK; the target stays silent until the next START.
- ADDR_ACK:
  - Drive low from the falling edge after bit 8 until the falling edge after the 9th clock.
  - R/W=0: go to PTR.
  - R/W=1: snapshot angle_in and magnet_detected into holding registers, load the byte at reg_ptr, pulse rd_strobe, go to RDATA.
- PTR:
  - Receive 8 bits, load reg_ptr, ACK, then go to WDATA.
- WDATA:
  - Further written bytes are ACKed and discarded; the device is read-only.
  - reg_ptr increments per byte.
- RDATA:
  - Drive data MSB first: sda_drive_low = ~bit, updated on each scl falling edge.
  - After bit 8, release SDA for the controller's ACK.
- RDATA_ACK:
  - Sample the controller bit on the scl rising edge.
  - ACK (0): reg_ptr+1, load the next byte, pulse rd_strobe, return to RDATA.
  - NACK (1): go to IDLE with busy held until STOP.
- Register read map:
  - STATUS_REG returns {2'b0, md, 5'b0}.
  - ANGLE_REG returns {4'h0, snap[11:8]}.
  - ANGLE_REG+1 returns snap[7:0].
  - ANGLE_REG+2 and ANGLE_REG+3 mirror ANGLE_REG and ANGLE_REG+1.
  - All other addresses read 0x00.
- Snapshot is taken only at the read-address ACK, so high and low bytes are always coherent within one transaction.
- reg_ptr wraps 0xFF to 0x00.
- SDA changing while scl is high in the middle of a byte is treated as START or STOP per the rules above.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- When defined:
  - Each synchronized line passes through a 3-sample majority filter.
  - Pulses of 1 clock cycle are rejected.
  - Condition-to-action latency becomes 5 cycles.
- When undefined: no filter; latency is 3 cycles.

Test Plan:
- Write 0x6C, 0x0C; repeated START; read 0x6D, 2 bytes, ACK then NACK; STOP; angle_in=12'hA5C -> ACKs on all address/pointer bytes; read bytes 0x0A, 0x5C; busy drops after STOP.
- Address 0x70 write -> no ACK (sda_drive_low stays 0 for the whole frame); reg_ptr unchanged.
- angle_in changes 0x123 to 0xFFF between byte 1 and byte 2 of a read from 0x0C -> returns 0x01, 0x23.
- Pointer 0xFF, read 2 bytes -> 0x00, 0x00; reg_ptr ends at 0x01 (wrap).
- Pointer 0x0B with magnet_detected=1 -> reads 0x20.
- reset_n asserted while the target drives ACK -> sda_drive_low=0 immediately; next START to 0x36 is ACKed normally.

Source files
------------

// File: rtl/i2c_encoder_target_if.sv
// I2C pad-side signals between a bus controller and the AS5600-style target.
interface i2c_encoder_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_drive_low;

    modport master (output scl_in, output sda_in, input sda_drive_low);
    modport slave  (input scl_in, input sda_in, output sda_drive_low);
endinterface

// File: rtl/i2c_encoder_target.sv
// I2C target emulating the AS5600 raw-angle/status registers at DEV_ADDR.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
//
// state     | meaning
// IDLE      | not addressed; ignore bus until START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR       | receiving register pointer
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | receiving (discarded) write data
// WDATA_ACK | driving ACK for write data
// RDATA     | shifting out read byte MSB first
// RDATA_ACK | sampling controller ACK/NACK
module i2c_encoder_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h36,
    parameter logic [7:0] STATUS_REG = 8'h0B,
    parameter logic [7:0] ANGLE_REG  = 8'h0C
) (
    input  logic                clock,
    input  logic                reset_n,
    i2c_encoder_target_if.slave bus,
    input  logic [11:0]         angle_in,
    input  logic                magnet_detected,
    output logic                busy,
    output logic [7:0]          reg_ptr,
    output logic                rd_strobe
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_line, sda_line;
    logic       scl_q, sda_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    // Majority over the current and two previous samples drops single-cycle pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                        (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                        (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync[1];
    assign sda_line = sda_sync[1];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_line;
            sda_q <= sda_line;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_line & ~scl_q;
    assign scl_fall   = ~scl_line & scl_q;
    assign start_cond = scl_line & scl_q & sda_q & ~sda_line;
    assign stop_cond  = scl_line & scl_q & ~sda_q & sda_line;

    function automatic logic [7:0] read_map(input logic [7:0] ptr, input logic [11:0] ang,
                                            input logic md);
        logic [7:0] off;
        read_map = 8'h00;
        off      = ptr - ANGLE_REG;
        if (ptr == STATUS_REG)
            read_map = {2'b00, md, 5'b00000};
        else if (off < 8'd4)
            read_map = off[0] ? ang[7:0] : {4'h0, ang[11:8]};
    endfunction

    state_t      state_q, state_nxt;
    logic [3:0]  bits_q, bits_nxt;
    logic [7:0]  shift_q, shift_nxt;
    logic [7:0]  tx_q, tx_nxt;
    logic        rw_q, rw_nxt;
    logic        ack_ph_q, ack_ph_nxt;
    logic        sda_drv_q, sda_drv_nxt;
    logic        busy_q, busy_nxt;
    logic [7:0]  ptr_q, ptr_nxt;
    logic        strobe_q, strobe_nxt;
    logic [11:0] snap_ang_q, snap_ang_nxt;
    logic        snap_md_q, snap_md_nxt;
    logic [7:0]  ptr_inc, cur_byte, next_byte;

    assign ptr_inc   = ptr_q + 8'd1;
    assign cur_byte  = read_map(ptr_q, snap_ang_q, snap_md_q);
    assign next_byte = read_map(ptr_inc, snap_ang_q, snap_md_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bits_q     <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            sda_drv_q  <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= 8'h00;
            strobe_q   <= 1'b0;
            snap_ang_q <= 12'h000;
            snap_md_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            bits_q     <= bits_nxt;
            shift_q    <= shift_nxt;
            tx_q       <= tx_nxt;
            rw_q       <= rw_nxt;
            ack_ph_q   <= ack_ph_nxt;
            sda_drv_q  <= sda_drv_nxt;
            busy_q     <= busy_nxt;
            ptr_q      <= ptr_nxt;
            strobe_q   <= strobe_nxt;
            snap_ang_q <= snap_ang_nxt;
            snap_md_q  <= snap_md_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        bits_nxt     = bits_q;
        shift_nxt    = shift_q;
        tx_nxt       = tx_q;
        rw_nxt       = rw_q;
        ack_ph_nxt   = ack_ph_q;
        sda_drv_nxt  = sda_drv_q;
        busy_nxt     = busy_q;
        ptr_nxt      = ptr_q;
        strobe_nxt   = 1'b0;
        snap_ang_nxt = snap_ang_q;
        snap_md_nxt  = snap_md_q;

        if (start_cond) begin
            state_nxt   = ADDR;
            bits_nxt    = 4'd8;
            sda_drv_nxt = 1'b0;
        end else if (stop_cond) begin
            state_nxt   = IDLE;
            sda_drv_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift_q[6:0], sda_line};
                        bits_nxt  = bits_q - 4'd1;
                        if (bits_q == 4'd1) begin
                            if (shift_q[6:0] == DEV_ADDR) begin
                                busy_nxt   = 1'b1;
                                rw_nxt     = sda_line;
                                ack_ph_nxt = 1'b0;
                                state_nxt  = ADDR_ACK;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_drv_nxt = 1'b1;
                            ack_ph_nxt  = 1'b1;
                            // Freeze the angle once so both bytes of a read are coherent.
                            if (rw_q) begin
                                snap_ang_nxt = angle_in;
                                snap_md_nxt  = magnet_detected;
                            end
                        end else begin
                            ack_ph_nxt = 1'b0;
                            bits_nxt   = 4'd8;
                            if (!rw_q) begin
                                sda_drv_nxt = 1'b0;
                                state_nxt   = PTR;
                            end else begin
                                sda_drv_nxt = ~cur_byte[7];
                                tx_nxt      = {cur_byte[6:0], 1'b0};
                                strobe_nxt  = 1'b1;
                                state_nxt   = RDATA;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift_q[6:0], sda_line};
                        bits_nxt  = bits_q - 4'd1;
                        if (bits_q == 4'd1) begin
                            ptr_nxt    = {shift_q[6:0], sda_line};
                            ack_ph_nxt = 1'b0;
                            state_nxt  = PTR_ACK;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_drv_nxt = 1'b1;
                            ack_ph_nxt  = 1'b1;
                        end else begin
                            sda_drv_nxt = 1'b0;
                            ack_ph_nxt  = 1'b0;
                            bits_nxt    = 4'd8;
                            state_nxt   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        bits_nxt = bits_q - 4'd1;
                        if (bits_q == 4'd1) begin
                            ptr_nxt    = ptr_inc;
                            ack_ph_nxt = 1'b0;
                            state_nxt  = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise && bits_q != 4'd0) begin
                        bits_nxt = bits_q - 4'd1;
                    end else if (scl_fall) begin
                        if (bits_q != 4'd0) begin
                            sda_drv_nxt = ~tx_q[7];
                            tx_nxt      = {tx_q[6:0], 1'b0};
                        end else begin
                            sda_drv_nxt = 1'b0;
                            state_nxt   = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    // The pointer moves past every byte sent, whether ACKed or NACKed.
                    if (scl_rise) begin
                        ptr_nxt = ptr_inc;
                        if (!sda_line) begin
                            tx_nxt     = next_byte;
                            bits_nxt   = 4'd8;
                            strobe_nxt = 1'b1;
                            state_nxt  = RDATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.sda_drive_low = sda_drv_q;
    assign busy              = busy_q;
    assign reg_ptr           = ptr_q;
    assign rd_strobe         = strobe_q;

endmodule

// File: tb/tb_i2c_encoder_target.sv
// Bit-banged I2C controller bench for i2c_encoder_target with a register-map reference model.
module tb_i2c_encoder_target;
    localparam int Q = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_ctrl = 1'b1;
    logic        sda_ctrl = 1'b1;
    logic [11:0] angle_in = 12'h000;
    logic        magnet_detected = 1'b0;
    logic        busy, rd_strobe;
    logic [7:0]  reg_ptr;

    i2c_encoder_target_if bus();
    assign bus.scl_in = scl_ctrl;
    assign bus.sda_in = sda_ctrl & ~bus.sda_drive_low;

    i2c_encoder_target dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .angle_in(angle_in),
        .magnet_detected(magnet_detected), .busy(busy), .reg_ptr(reg_ptr),
        .rd_strobe(rd_strobe)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int strobe_cnt = 0;
    int drive_cnt = 0;

    always @(posedge clock) begin
        if (rd_strobe) strobe_cnt++;
        if (bus.sda_drive_low) drive_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]       ptr;
        logic [11:0]      angle;
        bit               md;
        int               nbytes;
        int               nwrite;
        logic [3:0][7:0]  exp;
        logic [7:0]       exp_ptr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Register map from the datasheet-level rules.
    function automatic logic [7:0] model_byte(input int p, input int ang, input bit md);
        if (p == 'h0B) return md ? 8'h20 : 8'h00;
        if (p >= 'h0C && p <= 'h0F)
            return ((p - 'h0C) % 2 == 0) ? 8'(ang / 256) : 8'(ang % 256);
        return 8'h00;
    endfunction

    function automatic vec_t mk(input logic [7:0] p, input logic [11:0] a, input bit md,
                                input int n, input int w, input logic [7:0] e0,
                                input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] e3, input logic [7:0] ep);
        vec_t v;
        v.ptr = p; v.angle = a; v.md = md; v.nbytes = n; v.nwrite = w;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        v.exp_ptr = ep;
        return v;
    endfunction

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clock);
    endtask

    task automatic clk_bit(input bit b, output bit s);
        sda_ctrl = b;
        wait_q(1);
        scl_ctrl = 1'b1;
        wait_q(1);
        s = bus.sda_in;
        wait_q(1);
        scl_ctrl = 1'b0;
        wait_q(1);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1;
        wait_q(1);
        scl_ctrl = 1'b1;
        wait_q(1);
        sda_ctrl = 1'b0;
        wait_q(1);
        scl_ctrl = 1'b0;
        wait_q(1);
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0;
        wait_q(1);
        scl_ctrl = 1'b1;
        wait_q(1);
        sda_ctrl = 1'b1;
        wait_q(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit acked);
        bit s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit nack);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit         ack;
        logic [7:0] d;
        int         sb;
        angle_in        = v.angle;
        magnet_detected = v.md;
        i2c_start();
        write_byte(8'h6C, ack);
        check($sformatf("v%0d_addr_w_ack", idx), 32'(ack), 1);
        check($sformatf("v%0d_busy_addressed", idx), 32'(busy), 1);
        write_byte(v.ptr, ack);
        check($sformatf("v%0d_ptr_ack", idx), 32'(ack), 1);
        for (int w = 0; w < v.nwrite; w++) begin
            write_byte(8'($urandom), ack);
            check($sformatf("v%0d_wdata_ack%0d", idx, w), 32'(ack), 1);
        end
        i2c_start();
        sb = strobe_cnt;
        write_byte(8'h6D, ack);
        check($sformatf("v%0d_addr_r_ack", idx), 32'(ack), 1);
        for (int i = 0; i < v.nbytes; i++) begin
            read_byte(d, i == v.nbytes - 1);
            check($sformatf("v%0d_rd_byte%0d", idx, i), 32'(d), 32'(v.exp[i]));
        end
        check($sformatf("v%0d_rd_strobes", idx), 32'(strobe_cnt - sb), 32'(v.nbytes));
        check($sformatf("v%0d_busy_before_stop", idx), 32'(busy), 1);
        i2c_stop();
        check($sformatf("v%0d_busy_after_stop", idx), 32'(busy), 0);
        check($sformatf("v%0d_reg_ptr_end", idx), 32'(reg_ptr), 32'(v.exp_ptr));
    endtask

    vec_t vecs[16];

    initial begin
        bit         ack;
        logic [7:0] d0, d1, ptr_before;
        int         dc;
        int         plist[10] = '{'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h10, 'hFE, 'hFF, 0};

        vecs[0] = mk(8'h0C, 12'hA5C, 1'b0, 2, 0, 8'h0A, 8'h5C, 8'h00, 8'h00, 8'h0E);
        vecs[1] = mk(8'hFF, 12'h3C3, 1'b1, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        vecs[2] = mk(8'h0B, 12'h111, 1'b1, 1, 0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h0C);
        vecs[3] = mk(8'h0C, 12'hFFF, 1'b0, 4, 0, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h10);
        vecs[4] = mk(8'h0A, 12'h7E1, 1'b1, 3, 1, 8'h20, 8'h07, 8'hE1, 8'h00, 8'h0E);
        for (int k = 5; k < 16; k++) begin
            int p;
            p = plist[$urandom_range(0, 9)];
            if (p == 0) p = int'($urandom_range(0, 255));
            vecs[k].ptr     = 8'(p);
            vecs[k].angle   = 12'($urandom);
            vecs[k].md      = 1'($urandom);
            vecs[k].nbytes  = int'($urandom_range(1, 3));
            vecs[k].nwrite  = int'($urandom_range(0, 1));
            vecs[k].exp     = '0;
            for (int i = 0; i < vecs[k].nbytes; i++)
                vecs[k].exp[i] = model_byte((p + vecs[k].nwrite + i) % 256,
                                            int'(vecs[k].angle), vecs[k].md);
            vecs[k].exp_ptr = 8'((p + vecs[k].nwrite + vecs[k].nbytes) % 256);
        end

        repeat (4) @(negedge clock);
        check("rst_sda_drive_low", 32'(bus.sda_drive_low), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_reg_ptr", 32'(reg_ptr), 0);
        check("rst_rd_strobe", 32'(rd_strobe), 0);
        reset_n = 1'b1;
        wait_q(2);

        for (int k = 0; k < 16; k++) run_vec(vecs[k], k);

        // Foreign address: target must stay silent and keep its pointer.
        ptr_before = reg_ptr;
        dc = drive_cnt;
        i2c_start();
        write_byte(8'h70, ack);
        check("foreign_addr_ack", 32'(ack), 0);
        write_byte(8'h05, ack);
        check("foreign_data_ack", 32'(ack), 0);
        i2c_stop();
        check("foreign_drive_cycles", 32'(drive_cnt - dc), 0);
        check("foreign_reg_ptr", 32'(reg_ptr), 32'(ptr_before));

        // Angle changes between the two bytes of one read.
        angle_in = 12'h123;
        i2c_start();
        write_byte(8'h6C, ack);
        write_byte(8'h0C, ack);
        i2c_start();
        write_byte(8'h6D, ack);
        read_byte(d0, 1'b0);
        angle_in = 12'hFFF;
        read_byte(d1, 1'b1);
        i2c_stop();
        check("coherent_hi", 32'(d0), 32'h01);
        check("coherent_lo", 32'(d1), 32'h23);

        // Reset while the target drives ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            bit s;
            logic [7:0] a;
            a = 8'h6C;
            clk_bit(a[i], s);
        end
        sda_ctrl = 1'b1;
        wait_q(1);
        scl_ctrl = 1'b1;
        wait_q(1);
        check("ack_driving_before_reset", 32'(bus.sda_drive_low), 1);
        reset_n = 1'b0;
        #1;
        check("reset_releases_sda", 32'(bus.sda_drive_low), 0);
        wait_q(1);
        scl_ctrl = 1'b0;
        wait_q(1);
        reset_n = 1'b1;
        wait_q(2);
        check("post_reset_reg_ptr", 32'(reg_ptr), 0);
        check("post_reset_busy", 32'(busy), 0);
        i2c_start();
        write_byte(8'h6C, ack);
        check("post_reset_addr_ack", 32'(ack), 1);
        i2c_stop();
        check("post_reset_busy_after_stop", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
